// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: the sync byte and the state encodings
// of the loader FSM and the byte receiver.
package uart_program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loaderState_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rxState_t;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART byte receiver, LSB first, behind a 2-flop synchronizer.
// Ports: clk, rst (async active-high), rx (async serial in, idle high),
//        byte_valid (1-cycle pulse), byte_data (received byte), frm_err (1-cycle pulse, bad stop bit).
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frm_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic rxMeta, rxSync, rxPrev;
    rxState_t rxState, rxStateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0] bitIdx, bitIdxNext;
    logic [7:0] shiftReg, shiftNext, dataNext;
    logic validNext, errNext;

    // Synchronizer plus one extra stage for falling-edge detection; all idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // Receiver state register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxState    <= RX_IDLE;
            cnt        <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frm_err    <= 1'b0;
        end else begin
            rxState    <= rxStateNext;
            cnt        <= cntNext;
            bitIdx     <= bitIdxNext;
            shiftReg   <= shiftNext;
            byte_valid <= validNext;
            byte_data  <= dataNext;
            frm_err    <= errNext;
        end
    end

    // Next-state: start bit re-checked mid-bit, then one sample per bit period
    always_comb begin
        rxStateNext = rxState;
        cntNext     = cnt + CNT_W'(1);
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        validNext   = 1'b0;
        errNext     = 1'b0;
        dataNext    = byte_data;
        unique case (rxState)
            RX_IDLE: begin
                cntNext = '0;
                if (rxPrev && !rxSync) rxStateNext = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cntNext     = '0;
                    bitIdxNext  = '0;
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cntNext    = '0;
                    shiftNext  = {rxSync, shiftReg[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) rxStateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cntNext     = '0;
                    rxStateNext = RX_IDLE;
                    if (rxSync) begin
                        validNext = 1'b1;
                        dataNext  = shiftReg;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program over UART and writes it into text memory,
// holding the core in reset until a frame with a valid checksum has been loaded.
// Ports: clk, rst (async active-high), rx (UART in), imem_we/imem_addr/imem_wdata (text-memory
//        write port), core_rst (1 = core held), busy (frame in progress), error (sticky frame failure).
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 104,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  error
);

    // One extra index bit so a full 2^ADDR_WIDTH-word frame does not wrap
    localparam int unsigned IDX_W = ADDR_WIDTH + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic       byteValid, frmErr;
    logic [7:0] byteData;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxInst (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byteValid),
        .byte_data (byteData),
        .frm_err   (frmErr)
    );

    loaderState_t state, stateNext;
    logic [IDX_W-1:0] wordCount, wordCountNext, index, indexNext;
    logic [1:0]  byteCnt, byteCntNext;
    logic [31:0] wordBuf, wordBufNext;
    logic [7:0]  checksum, checksumNext;
    logic [TMR_W-1:0] timer, timerNext;
    logic inFrame, countBad;
    logic weNext, coreRstNext, busyNext, errorNext;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [31:0] wdataNext;

    // State register, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wordCount  <= '0;
            index      <= '0;
            byteCnt    <= '0;
            wordBuf    <= '0;
            checksum   <= '0;
            timer      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= stateNext;
            wordCount  <= wordCountNext;
            index      <= indexNext;
            byteCnt    <= byteCntNext;
            wordBuf    <= wordBufNext;
            checksum   <= checksumNext;
            timer      <= timerNext;
            imem_we    <= weNext;
            imem_addr  <= addrNext;
            imem_wdata <= wdataNext;
            core_rst   <= coreRstNext;
            busy       <= busyNext;
            error      <= errorNext;
        end
    end

    // Loader FSM, word assembly, checksum and inter-byte timer
    always_comb begin
        stateNext     = state;
        wordCountNext = wordCount;
        indexNext     = index;
        byteCntNext   = byteCnt;
        wordBufNext   = wordBuf;
        checksumNext  = checksum;
        weNext        = 1'b0;
        addrNext      = imem_addr;
        wdataNext     = imem_wdata;
        inFrame       = (state == COUNT) || (state == DATA) || (state == CHECK);
        countBad      = (byteData == 8'd0) || (32'(byteData) > (32'd1 << ADDR_WIDTH));

        unique case (state)
            IDLE: begin
                if (byteValid && byteData == SYNC_BYTE) stateNext = COUNT;
            end
            COUNT: begin
                if (byteValid) begin
                    if (countBad) begin
                        stateNext = ERROR;
                    end else begin
                        wordCountNext = IDX_W'(byteData);
                        indexNext     = '0;
                        byteCntNext   = '0;
                        checksumNext  = '0;
                        stateNext     = DATA;
                    end
                end
            end
            DATA: begin
                if (byteValid) begin
                    checksumNext = checksum ^ byteData;
                    byteCntNext  = byteCnt + 2'd1;
                    wordBufNext[{byteCnt, 3'b000} +: 8] = byteData;
                    if (byteCnt == 2'd3) begin
                        weNext    = 1'b1;
                        addrNext  = index[ADDR_WIDTH-1:0];
                        wdataNext = {byteData, wordBuf[23:0]};
                        indexNext = index + IDX_W'(1);
                        if ((index + IDX_W'(1)) == wordCount) stateNext = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byteValid) stateNext = (byteData == checksum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (byteValid && byteData == SYNC_BYTE) stateNext = COUNT;
            end
            default: stateNext = IDLE;
        endcase

        // A byte arriving in the same cycle as timer expiry takes precedence
        if (inFrame && !byteValid && (frmErr || timer == TMR_LAST)) stateNext = ERROR;
        timerNext = (inFrame && !byteValid) ? timer + TMR_W'(1) : '0;

        coreRstNext = (stateNext != DONE);
        busyNext    = (stateNext == COUNT) || (stateNext == DATA) || (stateNext == CHECK);
        errorNext   = (stateNext == ERROR);
    end

endmodule
